// File: rtl/nes_mem_pkg.sv
// Shared NES CPU-bus constants, the OAM DMA state type and the CPU-side bus payload.
package nes_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [ADDR_W-1:0] PPU_CTRL1 = 16'h2000;
  localparam logic [ADDR_W-1:0] OAM_ADDR  = 16'h2003;
  localparam logic [ADDR_W-1:0] OAM_DATA  = 16'h2004;
  localparam logic [ADDR_W-1:0] PPU_ADDR  = 16'h2006;
  localparam logic [ADDR_W-1:0] PPU_DATA  = 16'h2007;
  localparam logic [ADDR_W-1:0] OAM_DMA   = 16'h4014;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we;
    logic              re;
  } cpu_bus_t;

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Bus owner select: the CPU drives mem_decode while idle, the DMA engine while active.
module oam_dma_bus_mux
  import nes_mem_pkg::*;
(
  input  logic     i_dma_active,
  input  cpu_bus_t i_cpu_bus,
  input  cpu_bus_t i_dma_bus,
  output cpu_bus_t o_mem_bus
);

  always_comb begin
    o_mem_bus = i_cpu_bus;
    if (i_dma_active) o_mem_bus = i_dma_bus;
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// NES sprite DMA: a $4014 write halts the CPU and copies one page into SPRAM via $2004.
// Optional macro OAM_DMA_ODD_ALIGN_EN inserts one ALIGN cycle when the trigger lands on an odd cycle.
module oam_dma_ctrl
  import nes_mem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] DMA_REG_ADDR  = OAM_DMA,
  parameter logic [ADDR_W-1:0] OAM_DATA_ADDR = OAM_DATA,
  parameter int unsigned       XFER_LEN      = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr_in,
  input  logic [DATA_W-1:0] cpu_data_in,
  input  logic              cpu_write_en,
  input  logic              cpu_read_en,
  output logic [DATA_W-1:0] cpu_data_out,
  output logic              cpu_rdy,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              dma_active
);

  localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

  dma_state_t r_state;
  dma_state_t w_next_state;
  logic [7:0] r_page;
  logic [7:0] r_idx;
  logic       w_trigger;
  logic       w_align;
  cpu_bus_t   w_cpu_bus;
  cpu_bus_t   w_dma_bus;
  cpu_bus_t   w_mem_bus;

  assign w_trigger = cpu_write_en && (cpu_addr_in == DMA_REG_ADDR);

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic r_parity;

  // Free-running cycle parity used to decide on the extra alignment cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_parity <= 1'b0;
    else     r_parity <= ~r_parity;
  end

  assign w_align = r_parity;
`else
  assign w_align = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_next_state = HALT;
      HALT:    w_next_state = w_align ? ALIGN : READ;
      ALIGN:   w_next_state = READ;
      READ:    w_next_state = WRITE;
      WRITE:   w_next_state = (r_idx == IDX_LAST) ? IDLE : READ;
      default: w_next_state = IDLE;
    endcase
  end

  // Source page latch and byte index; the index stays inside the page.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_page <= 8'h00;
      r_idx  <= 8'h00;
    end else if (r_state == IDLE && w_trigger) begin
      r_page <= cpu_data_in;
      r_idx  <= 8'h00;
    end else if (r_state == WRITE) begin
      r_idx <= r_idx + 8'd1;
    end
  end

  always_comb begin
    w_dma_bus      = '0;
    w_dma_bus.addr = {r_page, r_idx};
    dma_active     = 1'b1;
    cpu_rdy        = 1'b0;
    case (r_state)
      IDLE: begin
        dma_active = 1'b0;
        cpu_rdy    = 1'b1;
      end
      READ:  w_dma_bus.re = 1'b1;
      WRITE: begin
        w_dma_bus.addr = OAM_DATA_ADDR;
        w_dma_bus.data = mem_data_in;
        w_dma_bus.we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_cpu_bus.addr = cpu_addr_in;
  assign w_cpu_bus.data = cpu_data_in;
  assign w_cpu_bus.we   = cpu_write_en;
  assign w_cpu_bus.re   = cpu_read_en;

  oam_dma_bus_mux u_bus_mux (
    .i_dma_active (dma_active),
    .i_cpu_bus    (w_cpu_bus),
    .i_dma_bus    (w_dma_bus),
    .o_mem_bus    (w_mem_bus)
  );

  assign mem_addr_out = w_mem_bus.addr;
  assign mem_data_out = w_mem_bus.data;
  assign mem_write_en = w_mem_bus.we;
  assign mem_read_en  = w_mem_bus.re;
  assign cpu_data_out = mem_data_in;

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences the CPU-side bus of mem_decode to perform NES sprite DMA.
- A CPU write to $4014 latches a source page.
- The block then halts the CPU and copies 256 bytes, {page,00}..{page,FF}, into SPRAM through repeated writes to $2004.
- Sits between the CPU core and mem_decode. It owns the mem_decode CPU port: pass-through when idle, DMA master when active.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, SPRAM data port address written during DMA.
- XFER_LEN, 256, bytes per transfer; must be a power of two ≤256.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr_in  in  16  CPU address.
- cpu_data_in  in  8  CPU write data.
- cpu_write_en  in  1  CPU write strobe.
- cpu_read_en  in  1  CPU read strobe.
- cpu_data_out  out  8  read data to CPU, = mem_data_in.
- cpu_rdy  out  1  low halts the CPU.
- mem_addr_out  out  16  address to mem_decode cpu_addr_in.
- mem_data_out  out  8  data to mem_decode cpu_data_in.
- mem_write_en  out  1  to mem_decode cpu_write_en.
- mem_read_en  out  1  to mem_decode cpu_read_en.
- mem_data_in  in  8  from mem_decode cpu_data_out; registered read, valid the cycle after the read request.
- dma_active  out  1  high while DMA owns the bus.

Behaviour:
- Reset values: state=IDLE, page=0, idx=0, parity=0, cpu_rdy=1, dma_active=0.
- Reset also forces all mem_* outputs to their pass-through values.
- parity: free-running 1-bit toggle every clock; reset 0.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE:
  - mem_* = cpu_* combinationally.
  - On edge with cpu_write_en=1 and cpu_addr_in==DMA_REG_ADDR: page<=cpu_data_in, idx<=0, go to HALT.
  - The trigger write itself is still passed through.
- HALT (1 cycle):
  - cpu_rdy=0, dma_active=1, mem_read_en=0, mem_write_en=0.
  - Next state is ALIGN if parity==1 in this cycle, else READ.
- ALIGN: 1 idle bus cycle, then READ.
- READ: mem_addr_out={page,idx}, mem_read_en=1, mem_write_en=0; next state WRITE.
- WRITE:
  - mem_addr_out=OAM_DATA_ADDR, mem_data_out=mem_data_in, mem_write_en=1, mem_read_en=0.
  - idx<=idx+1 (8-bit, wraps).
  - If idx==XFER_LEN-1, go to IDLE; else go to READ.
- Latency: trigger edge to first READ is 1 cycle (even) or 2 cycles (odd). Total halt is 513 or 514 cycles.
- cpu_rdy returns to 1 in the first IDLE cycle after the last WRITE.
- While dma_active=1, all cpu_* inputs are ignored, including further $4014 writes.
- Page $FF: source addresses are $FF00..$FFFF; no carry into the high byte.
- Page with idx wrap: the address never leaves the page.
- Async reset mid-transfer: immediate return to IDLE, cpu_rdy=1. The partial SPRAM contents are left as-is.
- Trigger with simultaneous cpu_read_en: the write takes priority; the read is ignored.

Optional Feature:
- OAM_DMA_ODD_ALIGN_EN.
- Defined: the ALIGN cycle is inserted when parity==1 in HALT (513/514 cycles).
- Undefined: ALIGN is never entered and the parity register is removed; always 513 cycles.

Decomposition:
- Shared package nes_mem_pkg holds:
  - Register address constants: PPU_CTRL1 $2000, OAM_ADDR $2003, OAM_DATA $2004, PPU_ADDR $2006, PPU_DATA $2007, OAM_DMA $4014.
  - The dma_state_t enum.
- Sub-module oam_dma_bus_mux: combinational owner select between the CPU bus and the DMA bus, driven by dma_active.

Test Plan:
1. Trigger with parity=0:
   - Preload CPU RAM $0200-$02FF with idx^8'hA5, write $2003=00, then $4014=02.
   - Expect cpu_rdy low for exactly 513 cycles.
   - Expect 256 writes to $2004; spram_ppu_data at addr n == n^A5.
2. Trigger with parity=1 (macro defined):
   - Expect 514 halt cycles and one ALIGN cycle with no mem strobes.
   - With the macro undefined, expect 513 cycles.
3. Page $07:
   - Expect the first read address $0700 and the last $07FF.
   - Expect no access outside the page; idx back at 0 in IDLE.
4. CPU activity during DMA:
   - Toggle cpu_write_en to $4014=05 and cpu_read_en mid-transfer.
   - Expect no effect on page or sequence; SPRAM matches the original page.
5. Reset mid-transfer:
   - Assert rst at idx=$40.
   - Expect immediate IDLE, cpu_rdy=1, dma_active=0.
   - A following $4014=03 runs a full clean transfer.
6. Idle pass-through:
   - CPU write $0123=5A, then read back.
   - Expect mem_* mirrors cpu_*, cpu_data_out=5A, cpu_rdy stays 1.
